// File: rtl/wb_stage_ext_pkg.sv
// Shared encodings for the write-back stage: load-size codes and the stage state.
package wb_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_FULL = 2'b10;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_WAIT   = 2'd1,
        WB_COMMIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_ext_if.sv
// MEM->WB handoff, memory return data, register-file write port and forwarding tap.
interface wb_stage_ext_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic                      mem_read_en;
    logic [1:0]                load_size;
    logic                      load_signed;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      mem_data_valid;
    logic                      stall;
    logic                      rf_write_en;
    logic [REG_ADDR_WIDTH-1:0] rf_write_addr;
    logic [DATA_WIDTH-1:0]     write_back_value;
    logic                      fwd_pending;
    logic [REG_ADDR_WIDTH-1:0] fwd_addr;

    modport slave (
        input  in_valid, flush, alu_result, mem_read_en, load_size, load_signed,
               wb_en, dest, mem_data, mem_data_valid,
        output in_ready, stall, rf_write_en, rf_write_addr, write_back_value,
               fwd_pending, fwd_addr
    );

    modport master (
        output in_valid, flush, alu_result, mem_read_en, load_size, load_signed,
               wb_en, dest, mem_data, mem_data_valid,
        input  in_ready, stall, rf_write_en, rf_write_addr, write_back_value,
               fwd_pending, fwd_addr
    );
endinterface

// File: rtl/wb_stage_ext_load_extract.sv
// Combinational load-data lane extraction with zero/sign extension.
module load_extract
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]       offset,
    input  logic [1:0]                            size,
    input  logic                                  sign_ext,
    output logic [DATA_WIDTH-1:0]                 result
);
    localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);

    logic [OFFSET_W+2:0]     byte_pos;
    logic [OFFSET_W+2:0]     half_pos;
    logic [7:0]              byte_val;
    logic [15:0]             half_val;
    logic [2*DATA_WIDTH-1:0] doubled;
    logic [DATA_WIDTH-1:0]   rotated;

    // Halfword lanes ignore offset bit 0, so the lane bit position drops it.
    assign byte_pos = {offset, 3'b000};
    assign half_pos = {offset[OFFSET_W-1:1], 4'b0000};
    assign byte_val = 8'(data >> byte_pos);
    assign half_val = 16'(data >> half_pos);

    // Unaligned full-width loads rotate the word right by the byte offset.
    assign doubled  = {data, data};
    assign rotated  = DATA_WIDTH'(doubled >> byte_pos);

    always_comb begin
        result = rotated;
        case (size)
            LS_BYTE: result = {{(DATA_WIDTH-8){sign_ext & byte_val[7]}}, byte_val};
            LS_HALF: result = {{(DATA_WIDTH-16){sign_ext & half_val[15]}}, half_val};
            default: result = rotated;
        endcase
    end
endmodule

// File: rtl/wb_stage_ext.sv
// Registered write-back stage: holds loads until data returns, then drives the
// register-file write port and exposes the pending destination for forwarding.
module wb_stage_ext
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    wb_stage_ext_if.slave bus
);
    localparam int OFFSET_W = $clog2(DATA_WIDTH / 8);

    wb_state_e                 state_q, state_d;
    logic [1:0]                size_q, size_d;
    logic                      sign_q, sign_d;
    logic [OFFSET_W-1:0]       off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                      wen_q, wen_d;
    logic [DATA_WIDTH-1:0]     result_q, result_d;

    logic                      in_wait;
    logic                      ready;
    logic                      accept;
    logic [1:0]                ext_size;
    logic                      ext_sign;
    logic [OFFSET_W-1:0]       ext_off;
    logic [DATA_WIDTH-1:0]     ext_data;

    assign in_wait = (state_q == WB_WAIT);
    assign ready   = ~in_wait & ~bus.flush;
    assign accept  = bus.in_valid & ready;

    // While waiting, extraction uses the captured load controls, not the live inputs.
    assign ext_size = in_wait ? size_q : bus.load_size;
    assign ext_sign = in_wait ? sign_q : bus.load_signed;
    assign ext_off  = in_wait ? off_q  : bus.alu_result[OFFSET_W-1:0];

    load_extract #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_extract (
        .data    (bus.mem_data),
        .offset  (ext_off),
        .size    (ext_size),
        .sign_ext(ext_sign),
        .result  (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        sign_d   = sign_q;
        off_d    = off_q;
        dest_d   = dest_q;
        wen_d    = wen_q;
        result_d = result_q;
        case (state_q)
            WB_WAIT: begin
                if (bus.flush) begin
                    state_d = WB_IDLE;
                end else if (bus.mem_data_valid) begin
                    state_d  = WB_COMMIT;
                    result_d = ext_data;
                end
            end
            default: begin
                if (accept) begin
                    size_d = bus.load_size;
                    sign_d = bus.load_signed;
                    off_d  = bus.alu_result[OFFSET_W-1:0];
                    dest_d = bus.dest;
                    wen_d  = bus.wb_en;
                    if (bus.mem_read_en && !bus.mem_data_valid) begin
                        state_d = WB_WAIT;
                    end else begin
                        state_d  = WB_COMMIT;
                        result_d = bus.mem_read_en ? ext_data : bus.alu_result;
                    end
                end else begin
                    state_d = WB_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WB_IDLE;
            size_q   <= LS_BYTE;
            sign_q   <= 1'b0;
            off_q    <= '0;
            dest_q   <= '0;
            wen_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            sign_q   <= sign_d;
            off_q    <= off_d;
            dest_q   <= dest_d;
            wen_q    <= wen_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready         = ready;
    assign bus.stall            = bus.in_valid & ~ready;
    // A flush during the commit cycle kills the write that is already on the port.
    assign bus.rf_write_en      = (state_q == WB_COMMIT) & wen_q & ~bus.flush;
    assign bus.rf_write_addr    = dest_q;
    assign bus.write_back_value = result_q;
    assign bus.fwd_pending      = in_wait;
    assign bus.fwd_addr         = in_wait ? dest_q : '0;
endmodule
